// File: rtl/instruction_fetch_unit.sv
// Single-issue instruction fetch with a one-entry skid buffer and redirect drain.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets raise a sticky fault and stop fetch.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   output logic        imem_read,
   output logic [31:0] imem_addr,
   input  logic        imem_busywait,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instruction,
   output logic        misaligned_fault
);

   localparam int unsigned    XLEN       = 32;
   localparam logic [XLEN-1:0] NOP_INSTR  = XLEN'(32'h0000_0013);
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(32'hFFFF_FFFC);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t            r_state,      w_state_nxt;
   logic              r_read,       w_read_nxt;
   logic [XLEN-1:0]   r_addr,       w_addr_nxt;
   logic [XLEN-1:0]   r_target,     w_target_nxt;
   logic              r_valid,      w_valid_nxt;
   logic [XLEN-1:0]   r_if_pc,      w_if_pc_nxt;
   logic [XLEN-1:0]   r_instr,      w_instr_nxt;
   logic [XLEN-1:0]   r_skid_pc,    w_skid_pc_nxt;
   logic [XLEN-1:0]   r_skid_instr, w_skid_instr_nxt;
   logic              r_fault,      w_fault_nxt;

   logic              w_resp;
   logic              w_misalign;
   logic [XLEN-1:0]   w_redir_pc;

   assign w_resp     = r_read & ~imem_busywait;
   assign w_redir_pc = redirect_pc & ALIGN_MASK;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign w_misalign = redirect_en & (redirect_pc[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   // Next-state and registered-output computation
   always_comb begin
      w_state_nxt      = r_state;
      w_read_nxt       = r_read;
      w_addr_nxt       = r_addr;
      w_target_nxt     = r_target;
      w_valid_nxt      = r_valid;
      w_if_pc_nxt      = r_if_pc;
      w_instr_nxt      = r_instr;
      w_skid_pc_nxt    = r_skid_pc;
      w_skid_instr_nxt = r_skid_instr;
      w_fault_nxt      = r_fault | w_misalign;

      if (redirect_en) begin
         // Redirect beats stall and any same-cycle response; leaving HOLD empties the skid
         w_valid_nxt = 1'b0;
         w_instr_nxt = NOP_INSTR;
         if (r_read && imem_busywait) begin
            w_state_nxt  = DRAIN;
            w_target_nxt = w_redir_pc;
            w_read_nxt   = 1'b1;
         end else begin
            w_state_nxt = FETCH;
            w_addr_nxt  = w_redir_pc;
            w_read_nxt  = ~w_fault_nxt;
         end
      end else begin
         unique case (r_state)
            FETCH: begin
               w_read_nxt = ~w_fault_nxt;
               if (!stall) begin
                  w_valid_nxt = 1'b0;
                  w_instr_nxt = NOP_INSTR;
               end
               if (w_resp) begin
                  w_addr_nxt = r_addr + PC_STEP;
                  if (!r_valid || !stall) begin
                     w_valid_nxt = 1'b1;
                     w_if_pc_nxt = r_addr;
                     w_instr_nxt = imem_rdata;
                  end else begin
                     w_skid_pc_nxt    = r_addr;
                     w_skid_instr_nxt = imem_rdata;
                     w_state_nxt      = HOLD;
                     w_read_nxt       = 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (!imem_busywait) begin
                  w_state_nxt = FETCH;
                  w_addr_nxt  = r_target;
                  w_read_nxt  = ~w_fault_nxt;
               end
            end
            HOLD: begin
               w_read_nxt = 1'b0;
               if (!stall) begin
                  w_valid_nxt = 1'b1;
                  w_if_pc_nxt = r_skid_pc;
                  w_instr_nxt = r_skid_instr;
                  w_state_nxt = FETCH;
                  w_read_nxt  = ~w_fault_nxt;
               end
            end
            default: begin
               w_state_nxt = FETCH;
               w_read_nxt  = 1'b0;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= FETCH;
         r_read       <= 1'b0;
         r_addr       <= RESET_PC;
         r_target     <= RESET_PC;
         r_valid      <= 1'b0;
         r_if_pc      <= '0;
         r_instr      <= NOP_INSTR;
         r_skid_pc    <= '0;
         r_skid_instr <= NOP_INSTR;
         r_fault      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_read       <= w_read_nxt;
         r_addr       <= w_addr_nxt;
         r_target     <= w_target_nxt;
         r_valid      <= w_valid_nxt;
         r_if_pc      <= w_if_pc_nxt;
         r_instr      <= w_instr_nxt;
         r_skid_pc    <= w_skid_pc_nxt;
         r_skid_instr <= w_skid_instr_nxt;
         r_fault      <= w_fault_nxt;
      end
   end

   assign imem_read        = r_read;
   assign imem_addr        = r_addr;
   assign if_valid         = r_valid;
   assign if_pc            = r_if_pc;
   assign if_instruction   = r_instr;
   assign misaligned_fault = r_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit against a zero/variable-wait memory model.
// Build with FETCH_MISALIGN_TRAP_EN defined to exercise the trap variant of the misalign test.
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        imem_read;
   logic [31:0] imem_addr;
   logic        imem_busywait;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instruction;
   logic        misaligned_fault;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk              (clk),
      .reset            (reset),
      .stall            (stall),
      .redirect_en      (redirect_en),
      .redirect_pc      (redirect_pc),
      .imem_read        (imem_read),
      .imem_addr        (imem_addr),
      .imem_busywait    (imem_busywait),
      .imem_rdata       (imem_rdata),
      .if_valid         (if_valid),
      .if_pc            (if_pc),
      .if_instruction   (if_instruction),
      .misaligned_fault (misaligned_fault)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0; imem_busywait = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      reset = 1'b1;
      tick();
      checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b expected 0", imem_read); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", if_pc); end
      checks++; if (if_instruction !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", if_instruction, NOP); end
      checks++; if (misaligned_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", misaligned_fault); end
      reset = 1'b0;
      tick();
      checks++; if (imem_read !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req: got read=%b addr=%h expected read=1 addr=0", imem_read, imem_addr); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL first_cycle_valid: got %b expected 0", if_valid); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (if_valid !== 1'b1 || if_pc !== 32'(i * 4) || if_instruction !== mem_word(32'(i * 4))) begin
            errors++;
            $display("FAIL seq_%0d: got valid=%b pc=%h instr=%h expected valid=1 pc=%h instr=%h",
                     i, if_valid, if_pc, if_instruction, 32'(i * 4), mem_word(32'(i * 4)));
         end
      end
   endtask

   task automatic test_busywait();
      apply_reset();
      tick(); tick(); tick();
      checks++; if (imem_addr !== 32'h8 || if_pc !== 32'h4) begin errors++; $display("FAIL bw_setup: got addr=%h pc=%h expected addr=8 pc=4", imem_addr, if_pc); end
      imem_busywait = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (imem_addr !== 32'h8 || imem_read !== 1'b1 || if_valid !== 1'b0 || if_instruction !== NOP) begin
            errors++;
            $display("FAIL bw_hold_%0d: got addr=%h read=%b valid=%b instr=%h expected addr=8 read=1 valid=0 instr=%h",
                     i, imem_addr, imem_read, if_valid, if_instruction, NOP);
         end
      end
      imem_busywait = 1'b0;
      tick();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instruction !== mem_word(32'h8) || imem_addr !== 32'hC) begin
         errors++;
         $display("FAIL bw_release: got valid=%b pc=%h instr=%h addr=%h expected valid=1 pc=8 instr=%h addr=c",
                  if_valid, if_pc, if_instruction, imem_addr, mem_word(32'h8));
      end
   endtask

   task automatic test_stall();
      apply_reset();
      for (int i = 0; i < 6; i++) tick();
      checks++; if (if_pc !== 32'h10 || imem_addr !== 32'h14) begin errors++; $display("FAIL st_setup: got pc=%h addr=%h expected pc=10 addr=14", if_pc, imem_addr); end
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instruction !== mem_word(32'h10) || imem_read !== 1'b0) begin
            errors++;
            $display("FAIL st_hold_%0d: got valid=%b pc=%h instr=%h read=%b expected valid=1 pc=10 instr=%h read=0",
                     i, if_valid, if_pc, if_instruction, imem_read, mem_word(32'h10));
         end
      end
      stall = 1'b0;
      tick();
      checks++;
      if (if_pc !== 32'h14 || if_instruction !== mem_word(32'h14) || imem_read !== 1'b1 || imem_addr !== 32'h18) begin
         errors++;
         $display("FAIL st_skid: got pc=%h instr=%h read=%b addr=%h expected pc=14 instr=%h read=1 addr=18",
                  if_pc, if_instruction, imem_read, imem_addr, mem_word(32'h14));
      end
      tick();
      checks++; if (if_pc !== 32'h18 || if_valid !== 1'b1) begin errors++; $display("FAIL st_next: got pc=%h valid=%b expected pc=18 valid=1", if_pc, if_valid); end
   endtask

   task automatic test_redirect_drain();
      apply_reset();
      for (int i = 0; i < 9; i++) tick();
      checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL rd_setup: got addr=%h expected 20", imem_addr); end
      imem_busywait = 1'b1;
      tick();
      redirect_en = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_en = 1'b0;
      checks++; if (imem_addr !== 32'h20 || imem_read !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL rd_drain: got addr=%h read=%b valid=%b expected addr=20 read=1 valid=0", imem_addr, imem_read, if_valid); end
      tick();
      checks++; if (imem_addr !== 32'h20 || if_valid !== 1'b0) begin errors++; $display("FAIL rd_drain2: got addr=%h valid=%b expected addr=20 valid=0", imem_addr, if_valid); end
      imem_busywait = 1'b0;
      tick();
      checks++; if (imem_addr !== 32'h100 || if_valid !== 1'b0 || if_instruction !== NOP) begin errors++; $display("FAIL rd_discard: got addr=%h valid=%b instr=%h expected addr=100 valid=0 instr=%h", imem_addr, if_valid, if_instruction, NOP); end
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instruction !== mem_word(32'h100)) begin errors++; $display("FAIL rd_target: got valid=%b pc=%h instr=%h expected valid=1 pc=100 instr=%h", if_valid, if_pc, if_instruction, mem_word(32'h100)); end
   endtask

   task automatic test_redirect_priority();
      stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect_en = 1'b0;
      checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h200 || imem_read !== 1'b1) begin errors++; $display("FAIL pr_redirect: got valid=%b addr=%h read=%b expected valid=0 addr=200 read=1", if_valid, imem_addr, imem_read); end
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin errors++; $display("FAIL pr_load: got valid=%b pc=%h expected valid=1 pc=200", if_valid, if_pc); end
      imem_busywait = 1'b1;
      tick();
      redirect_en = 1'b1; redirect_pc = 32'h300;
      tick();
      redirect_pc = 32'h400;
      tick();
      redirect_en = 1'b0; imem_busywait = 1'b0;
      tick();
      checks++; if (imem_addr !== 32'h400 || if_valid !== 1'b0) begin errors++; $display("FAIL pr_last_wins: got addr=%h valid=%b expected addr=400 valid=0", imem_addr, if_valid); end
      stall = 1'b0;
      tick();
      checks++; if (if_pc !== 32'h400 || if_valid !== 1'b1) begin errors++; $display("FAIL pr_last_fetch: got pc=%h valid=%b expected pc=400 valid=1", if_pc, if_valid); end
   endtask

   task automatic test_wrap();
      redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect_en = 1'b0;
      tick();
      tick();
      checks++; if (if_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got pc=%h addr=%h expected pc=fffffffc addr=0", if_pc, imem_addr); end
      tick();
      checks++; if (if_pc !== 32'h0 || if_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc: got pc=%h valid=%b expected pc=0 valid=1", if_pc, if_valid); end
   endtask

   task automatic test_misalign();
      apply_reset();
      tick(); tick();
      redirect_en = 1'b1; redirect_pc = 32'h102;
      tick();
      redirect_en = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      checks++; if (misaligned_fault !== 1'b1 || if_valid !== 1'b0 || imem_read !== 1'b0) begin errors++; $display("FAIL ma_trap: got fault=%b valid=%b read=%b expected fault=1 valid=0 read=0", misaligned_fault, if_valid, imem_read); end
      for (int i = 0; i < 3; i++) tick();
      checks++; if (misaligned_fault !== 1'b1 || imem_read !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL ma_stopped: got fault=%b read=%b valid=%b expected fault=1 read=0 valid=0", misaligned_fault, imem_read, if_valid); end
`else
      checks++; if (misaligned_fault !== 1'b0 || imem_addr !== 32'h100 || imem_read !== 1'b1) begin errors++; $display("FAIL ma_mask: got fault=%b addr=%h read=%b expected fault=0 addr=100 read=1", misaligned_fault, imem_addr, imem_read); end
      tick();
      checks++; if (if_pc !== 32'h100 || if_valid !== 1'b1) begin errors++; $display("FAIL ma_fetch: got pc=%h valid=%b expected pc=100 valid=1", if_pc, if_valid); end
`endif
   endtask

   initial begin
      test_reset();
      test_busywait();
      test_stall();
      test_redirect_drain();
      test_redirect_priority();
      test_wrap();
      test_misalign();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
